tiger_ks_ctrl: RTL and testbench



---
 rtl/tiger_ks_ctrl.sv | 137 +++++++++++++
 tb/tb_tiger_ks_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiger_ks_ctrl.sv
// Tiger key-schedule sequencer: presents PASSES key sets per 512-bit block to the round engine.
// Optional block counter output o_blk_cnt is enabled by defining TIGER_KS_CTRL_STAT_EN.
module tiger_key_sch (
  input  logic         clk,
  input  logic         en,
  input  logic [511:0] key_in,
  output logic [511:0] key_out
);

  function automatic logic [511:0] key_sched(input logic [511:0] k);
    logic [63:0] x [8];
    for (int i = 0; i < 8; i++) x[i] = k[511-64*i -: 64];
    x[0] = x[0] - (x[7] ^ 64'hA5A5_A5A5_A5A5_A5A5);
    x[1] = x[1] ^ x[0];
    x[2] = x[2] + x[1];
    x[3] = x[3] - (x[2] ^ ((~x[1]) << 19));
    x[4] = x[4] ^ x[3];
    x[5] = x[5] + x[4];
    x[6] = x[6] - (x[5] ^ ((~x[4]) >> 23));
    x[7] = x[7] ^ x[6];
    x[0] = x[0] + x[7];
    x[1] = x[1] - (x[0] ^ ((~x[7]) << 19));
    x[2] = x[2] ^ x[1];
    x[3] = x[3] + x[2];
    x[4] = x[4] - (x[3] ^ ((~x[2]) >> 23));
    x[5] = x[5] ^ x[4];
    x[6] = x[6] + x[5];
    x[7] = x[7] - (x[6] ^ 64'h0123_4567_89AB_CDEF);
    return {x[0], x[1], x[2], x[3], x[4], x[5], x[6], x[7]};
  endfunction

  // Single register stage; data only, no reset needed since it is sampled after a load.
  always_ff @(posedge clk) begin
    if (en) key_out <= key_sched(key_in);
  end

endmodule

module tiger_ks_ctrl #(
  parameter int PASSES = 3,
  parameter int PASS_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_blk_vld,
  output logic              o_blk_rdy,
  input  logic [511:0]      i_blk,
  output logic              o_key_vld,
  input  logic              i_key_rdy,
  output logic [511:0]      o_key,
  output logic [PASS_W-1:0] o_pass,
  input  logic              i_abort,
  output logic              o_done
`ifdef TIGER_KS_CTRL_STAT_EN
  ,
  output logic [31:0]       o_blk_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, PRESENT, SCHED, CAPT} state_t;

  state_t              state;
  logic [511:0]        key;
  logic [PASS_W-1:0]   pass;
  logic [511:0]        sch_out;
  logic                last;

  assign o_key  = key;
  assign o_pass = pass;
  assign last   = (pass == PASS_W'(PASSES - 1));

  tiger_key_sch u_sch (
    .clk     (i_clk),
    .en      (state == SCHED),
    .key_in  (key),
    .key_out (sch_out)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      key       <= '0;
      pass      <= '0;
      o_key_vld <= 1'b0;
      o_done    <= 1'b0;
      o_blk_rdy <= 1'b1;
`ifdef TIGER_KS_CTRL_STAT_EN
      o_blk_cnt <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      // Abort wins over any handshake; an idle controller ignores it.
      if (i_abort && state != IDLE) begin
        state     <= IDLE;
        pass      <= '0;
        o_key_vld <= 1'b0;
        o_blk_rdy <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (i_blk_vld && o_blk_rdy) begin
              key       <= i_blk;
              pass      <= '0;
              state     <= PRESENT;
              o_key_vld <= 1'b1;
              o_blk_rdy <= 1'b0;
            end
          end
          PRESENT: begin
            if (i_key_rdy) begin
              o_key_vld <= 1'b0;
              if (last) begin
                state     <= IDLE;
                o_done    <= 1'b1;
                o_blk_rdy <= 1'b1;
`ifdef TIGER_KS_CTRL_STAT_EN
                o_blk_cnt <= o_blk_cnt + 32'd1;
`endif
              end else begin
                state <= SCHED;
              end
            end
          end
          SCHED: state <= CAPT;
          CAPT: begin
            key       <= sch_out;
            pass      <= pass + PASS_W'(1);
            state     <= PRESENT;
            o_key_vld <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tiger_ks_ctrl.sv
// Randomized bench for tiger_ks_ctrl: a PASSES=3 instance and a PASSES=4 instance against a key-set model.
module tb_tiger_ks_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         blk_vld = 1'b0, blk_rdy, key_vld, key_rdy = 1'b0, abort = 1'b0, done;
  logic [511:0] blk = '0, key;
  logic [2:0]   pass;
  logic         blk_vld4 = 1'b0, blk_rdy4, key_vld4, key_rdy4 = 1'b0, abort4 = 1'b0, done4;
  logic [511:0] blk4 = '0, key4;
  logic [2:0]   pass4;
`ifdef TIGER_KS_CTRL_STAT_EN
  logic [31:0]  cnt3, cnt4;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  tiger_ks_ctrl #(.PASSES(3), .PASS_W(3)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_blk_vld(blk_vld), .o_blk_rdy(blk_rdy), .i_blk(blk),
    .o_key_vld(key_vld), .i_key_rdy(key_rdy), .o_key(key), .o_pass(pass),
    .i_abort(abort), .o_done(done)
`ifdef TIGER_KS_CTRL_STAT_EN
    , .o_blk_cnt(cnt3)
`endif
  );

  tiger_ks_ctrl #(.PASSES(4), .PASS_W(3)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_blk_vld(blk_vld4), .o_blk_rdy(blk_rdy4), .i_blk(blk4),
    .o_key_vld(key_vld4), .i_key_rdy(key_rdy4), .o_key(key4), .o_pass(pass4),
    .i_abort(abort4), .o_done(done4)
`ifdef TIGER_KS_CTRL_STAT_EN
    , .o_blk_cnt(cnt4)
`endif
  );

  // Tiger key schedule on eight 64-bit words, x0 in the top bits.
  function automatic logic [511:0] ks(input logic [511:0] k);
    logic [63:0] x [8];
    for (int i = 0; i < 8; i++) x[i] = k[511-64*i -: 64];
    x[0] -= x[7] ^ 64'hA5A5A5A5A5A5A5A5;
    x[1] ^= x[0];
    x[2] += x[1];
    x[3] -= x[2] ^ ((~x[1]) << 19);
    x[4] ^= x[3];
    x[5] += x[4];
    x[6] -= x[5] ^ ((~x[4]) >> 23);
    x[7] ^= x[6];
    x[0] += x[7];
    x[1] -= x[0] ^ ((~x[7]) << 19);
    x[2] ^= x[1];
    x[3] += x[2];
    x[4] -= x[3] ^ ((~x[2]) >> 23);
    x[5] ^= x[4];
    x[6] += x[5];
    x[7] -= x[6] ^ 64'h0123456789ABCDEF;
    return {x[0], x[1], x[2], x[3], x[4], x[5], x[6], x[7]};
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one full block through the PASSES=3 instance and checks every key set, its timing and o_done.
  task automatic run_block(input logic [511:0] b, input int stall_pass, input int stall_len, input bit rnd);
    logic [511:0] exp_k;
    int n, cyc, stalls, s;
    n = 0;
    while (!blk_rdy && n < 20) begin step(); n++; end
    vecs++;
    if (blk_rdy !== 1'b1) begin errs++; $display("FAIL blk_rdy_wait got=%b want=1", blk_rdy); end
    blk_vld = 1'b1; blk = b; step(); blk_vld = 1'b0;
    cyc = 1; stalls = 0; exp_k = b;
    for (int p = 0; p < 3; p++) begin
      n = 0;
      while (!key_vld && n < 10) begin
        vecs++;
        if (done !== 1'b0) begin errs++; $display("FAIL early_done p=%0d got=%b want=0", p, done); end
        step(); n++; cyc++;
      end
      vecs++;
      if (n !== (p == 0 ? 0 : 2)) begin errs++; $display("FAIL latency p=%0d got=%0d want=%0d", p, n, (p == 0 ? 0 : 2)); end
      vecs++;
      if (key !== exp_k || pass !== 3'(p)) begin
        errs++; $display("FAIL key p=%0d pass got=%0d want=%0d key got=%h want=%h", p, pass, p, key, exp_k);
      end
      s = (p == stall_pass) ? stall_len : (rnd ? $urandom_range(0, 3) : 0);
      for (int i = 0; i < s; i++) begin
        step(); cyc++; stalls++;
        vecs++;
        if (key_vld !== 1'b1 || key !== exp_k || pass !== 3'(p)) begin
          errs++; $display("FAIL hold p=%0d vld=%b pass got=%0d want=%0d", p, key_vld, pass, p);
        end
      end
      key_rdy = 1'b1; step(); key_rdy = 1'b0; cyc++;
      exp_k = ks(exp_k);
    end
    vecs++;
    if (done !== 1'b1 || blk_rdy !== 1'b1 || key_vld !== 1'b0) begin
      errs++; $display("FAIL block_end done=%b rdy=%b vld=%b want 1 1 0", done, blk_rdy, key_vld);
    end
    vecs++;
    if (cyc !== 8 + stalls) begin errs++; $display("FAIL rdy_return got=%0d want=%0d", cyc, 8 + stalls); end
    step();
    vecs++;
    if (done !== 1'b0) begin errs++; $display("FAIL done_pulse got=%b want=0", done); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    vecs++;
    if (blk_rdy !== 1'b1 || key_vld !== 1'b0 || done !== 1'b0 || pass !== 3'd0 || key !== '0) begin
      errs++; $display("FAIL reset3 rdy=%b vld=%b done=%b pass=%0d key=%h", blk_rdy, key_vld, done, pass, key);
    end
    vecs++;
    if (blk_rdy4 !== 1'b1 || key_vld4 !== 1'b0 || done4 !== 1'b0 || pass4 !== 3'd0 || key4 !== '0) begin
      errs++; $display("FAIL reset4 rdy=%b vld=%b done=%b pass=%0d", blk_rdy4, key_vld4, done4, pass4);
    end
  endtask

  task automatic test_single();
    run_block('0, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_block(rand_blk(), 1, 5, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) run_block(rand_blk(), -1, 0, 1'b1);
  endtask

  task automatic test_abort();
    logic [511:0] b;
    int n;
    b = {8{64'h0123456789abcdef}};
    blk_vld = 1'b1; blk = b; step(); blk_vld = 1'b0;
    key_rdy = 1'b1; step(); key_rdy = 1'b0;
    abort = 1'b1; step(); abort = 1'b0;
    vecs++;
    if (key_vld !== 1'b0 || blk_rdy !== 1'b1 || pass !== 3'd0 || done !== 1'b0) begin
      errs++; $display("FAIL abort_sched vld=%b rdy=%b pass=%0d done=%b", key_vld, blk_rdy, pass, done);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      vecs++;
      if (done !== 1'b0 || key_vld !== 1'b0) begin errs++; $display("FAIL abort_quiet done=%b vld=%b", done, key_vld); end
    end
    run_block(rand_blk(), -1, 0, 1'b1);
    // Abort together with the final handshake must suppress o_done.
    blk_vld = 1'b1; blk = b; step(); blk_vld = 1'b0;
    key_rdy = 1'b1; n = 0;
    while (!(key_vld && pass == 3'd2) && n < 20) begin step(); n++; end
    vecs++;
    if (key_vld !== 1'b1 || pass !== 3'd2) begin errs++; $display("FAIL reach_last vld=%b pass=%0d want 1 2", key_vld, pass); end
    abort = 1'b1; step(); abort = 1'b0; key_rdy = 1'b0;
    vecs++;
    if (done !== 1'b0 || key_vld !== 1'b0 || blk_rdy !== 1'b1 || pass !== 3'd0) begin
      errs++; $display("FAIL abort_prio done=%b vld=%b rdy=%b pass=%0d", done, key_vld, blk_rdy, pass);
    end
    step();
    vecs++;
    if (done !== 1'b0) begin errs++; $display("FAIL abort_prio_late done=%b want=0", done); end
    // In IDLE the abort is ignored and the block is accepted.
    b = rand_blk();
    blk_vld = 1'b1; abort = 1'b1; blk = b; step(); blk_vld = 1'b0; abort = 1'b0;
    vecs++;
    if (key_vld !== 1'b1 || pass !== 3'd0 || key !== b) begin
      errs++; $display("FAIL idle_abort vld=%b pass=%0d key=%h want=%h", key_vld, pass, key, b);
    end
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [511:0] b;
    int n;
    b = rand_blk();
    blk_vld = 1'b1; blk = b; step(); blk_vld = 1'b0;
    key_rdy = 1'b1; step(); key_rdy = 1'b0;
    n = 0;
    while (!key_vld && n < 10) begin step(); n++; end
    vecs++;
    if (pass !== 3'd1 || key !== ks(b)) begin errs++; $display("FAIL pre_reset pass=%0d want=1", pass); end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if (key_vld !== 1'b0 || done !== 1'b0 || pass !== 3'd0 || key !== '0) begin
      errs++; $display("FAIL async_reset vld=%b done=%b pass=%0d key=%h", key_vld, done, pass, key);
    end
    step();
    rst = 1'b0;
    step();
    vecs++;
    if (blk_rdy !== 1'b1 || done !== 1'b0) begin errs++; $display("FAIL post_reset rdy=%b done=%b", blk_rdy, done); end
    run_block(rand_blk(), 2, 2, 1'b0);
  endtask

  task automatic test_passes4();
    logic [511:0] exp_k;
    int cyc, hs;
    key_rdy4 = 1'b1;
    for (int blkn = 0; blkn < 2; blkn++) begin
      exp_k = rand_blk();
      blk_vld4 = 1'b1; blk4 = exp_k; step(); blk_vld4 = 1'b0;
      cyc = 1; hs = 0;
      while (!blk_rdy4 && cyc < 40) begin
        if (key_vld4) begin
          vecs++;
          if (pass4 !== 3'(hs) || key4 !== exp_k) begin
            errs++; $display("FAIL p4_key hs=%0d pass got=%0d key got=%h want=%h", hs, pass4, key4, exp_k);
          end
          exp_k = ks(exp_k); hs++;
        end
        step(); cyc++;
      end
      vecs++;
      if (hs !== 4 || cyc !== 11 || done4 !== 1'b1) begin
        errs++; $display("FAIL p4_block hs=%0d cyc=%0d done=%b want 4 11 1", hs, cyc, done4);
      end
    end
    step();
`ifdef TIGER_KS_CTRL_STAT_EN
    vecs++;
    if (cnt4 !== 32'd2) begin errs++; $display("FAIL p4_cnt got=%0d want=2", cnt4); end
`endif
    blk_vld4 = 1'b1; blk4 = rand_blk(); key_rdy4 = 1'b0; step(); blk_vld4 = 1'b0;
    key_rdy4 = 1'b1; step();
    abort4 = 1'b1; step(); abort4 = 1'b0; key_rdy4 = 1'b0;
    step();
    vecs++;
    if (done4 !== 1'b0 || blk_rdy4 !== 1'b1 || key_vld4 !== 1'b0) begin
      errs++; $display("FAIL p4_abort done=%b rdy=%b vld=%b", done4, blk_rdy4, key_vld4);
    end
`ifdef TIGER_KS_CTRL_STAT_EN
    vecs++;
    if (cnt4 !== 32'd2) begin errs++; $display("FAIL p4_cnt_abort got=%0d want=2", cnt4); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_random();
    test_abort();
    test_async_reset();
    test_passes4();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
